// File: rtl/bitonic_pkg.sv
// Shared helpers for the pipelined bitonic sorter: stage count and the
// per-layer pairing/direction tables, all evaluated at elaboration time.
package bitonic_pkg;

  localparam int MAX_LOG_N = 5;

  // Number of compare layers in a full bitonic sort of 2^log_n elements.
  function automatic int stage_count(input int log_n);
    return (log_n * (log_n + 1)) / 2;
  endfunction

  // Compare distance j of a flat layer index (layers enumerate phase p=1..,
  // and within phase p the distances 2^(p-1) down to 1).
  function automatic int layer_dist(input int layer);
    int l;
    int d;
    l = layer;
    d = 1;
    for (int p = 1; p <= MAX_LOG_N; p++) begin
      if (l >= 0 && l < p) begin
        d = 32'sd1 << (p - 1 - l);
      end else begin
        d = d;
      end
      l = l - p;
    end
    return d;
  endfunction

  // Block size k of the phase a flat layer index belongs to.
  function automatic int layer_block(input int layer);
    int l;
    int k;
    l = layer;
    k = 2;
    for (int p = 1; p <= MAX_LOG_N; p++) begin
      if (l >= 0 && l < p) begin
        k = 32'sd1 << p;
      end else begin
        k = k;
      end
      l = l - p;
    end
    return k;
  endfunction

  // Index of the element paired with idx in the given layer.
  function automatic int pair_partner(input int layer, input int idx);
    return idx ^ layer_dist(layer);
  endfunction

  // Pair direction for the lower index of a pair: 0 = ascending, 1 = descending.
  function automatic logic pair_dir(input int layer, input int idx);
    return ((idx & layer_block(layer)) != 0) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/bitonic_cas.sv
// Combinational compare-and-swap of one pair. The compared word is
// {key, tag}; with TAG_W = 0 it is the bare key. Equal words never swap.
module bitonic_cas #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 0
) (
  input  logic [DATA_W+TAG_W-1:0] a,
  input  logic [DATA_W+TAG_W-1:0] b,
  input  logic                    dir,
  output logic [DATA_W+TAG_W-1:0] lo,
  output logic [DATA_W+TAG_W-1:0] hi
);

  logic swap_s;

  // Order the pair: lo gets the smaller word when ascending, the larger when descending.
  always_comb begin
    if (dir) begin
      swap_s = (a < b);
    end else begin
      swap_s = (a > b);
    end
    if (swap_s) begin
      lo = b;
      hi = a;
    end else begin
      lo = a;
      hi = b;
    end
  end

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorter with valid/ready handshake and global stall.
// One register stage per compare layer; each stage carries data, valid and
// the per-transaction sort direction. Optional argsort output is enabled by
// defining BITONIC_SORT_TAG_EN (adds out_tag and tag bits in every stage).
module bitonic_sort_pipe
  import bitonic_pkg::*;
#(
  parameter  int LOG_N  = 3,
  parameter  int DATA_W = 8,
  localparam int N      = 32'sd1 << LOG_N,
  localparam int STAGES = stage_count(LOG_N),
  localparam int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_desc,
  input  logic [N*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_desc,
  output logic [N*DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]    occupancy
`ifdef BITONIC_SORT_TAG_EN
  ,
  output logic [N*LOG_N-1:0]  out_tag
`endif
);

`ifdef BITONIC_SORT_TAG_EN
  localparam int TAG_W = LOG_N;
`else
  localparam int TAG_W = 0;
`endif
  localparam int EW = DATA_W + TAG_W;

  typedef logic [N-1:0][EW-1:0] vec_t;

  vec_t              in_vec_s;
  vec_t              lay_in_s  [STAGES];
  vec_t              lay_out_s [STAGES];
  vec_t              stage_d   [STAGES];
  vec_t              stage_q   [STAGES];
  logic [STAGES-1:0] vin_s;
  logic [STAGES-1:0] desc_in_s;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] desc_d;
  logic [STAGES-1:0] desc_q;
  logic [OCC_W-1:0]  occ_d;
  logic [OCC_W-1:0]  occ_q;
  logic              advance_s;
  logic              in_fire_s;
  logic              out_fire_s;

  // Unpack the input bus into elements, attaching the original index as tag.
  always_comb begin
    for (int i = 0; i < N; i++) begin
`ifdef BITONIC_SORT_TAG_EN
      in_vec_s[i] = {in_data[i*DATA_W +: DATA_W], TAG_W'(i)};
`else
      in_vec_s[i] = in_data[i*DATA_W +: DATA_W];
`endif
    end
  end

  // Compare network: layer s reads the previous stage register (or the input).
  for (genvar s = 0; s < STAGES; s++) begin : g_layer
    if (s == 0) begin : g_first
      assign lay_in_s[s]  = in_vec_s;
      assign vin_s[s]     = in_valid;
      assign desc_in_s[s] = in_desc;
    end else begin : g_next
      assign lay_in_s[s]  = stage_q[s-1];
      assign vin_s[s]     = valid_q[s-1];
      assign desc_in_s[s] = desc_q[s-1];
    end

    // The last LOG_N layers form the final merge; desc flips their direction.
    localparam logic FINAL_MERGE = (s >= STAGES - LOG_N) ? 1'b1 : 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_elem
      localparam int   PARTNER = pair_partner(s, i);
      localparam logic PDIR    = pair_dir(s, i);
      if (PARTNER > i) begin : g_cas
        bitonic_cas #(
          .DATA_W (DATA_W),
          .TAG_W  (TAG_W)
        ) u_cas (
          .a   (lay_in_s[s][i]),
          .b   (lay_in_s[s][PARTNER]),
          .dir (PDIR ^ (FINAL_MERGE & desc_in_s[s])),
          .lo  (lay_out_s[s][i]),
          .hi  (lay_out_s[s][PARTNER])
        );
      end
    end
  end

  assign advance_s  = !valid_q[STAGES-1] || out_ready;
  assign in_fire_s  = in_valid && advance_s;
  assign out_fire_s = valid_q[STAGES-1] && out_ready;

  // Global stall: every stage shifts together on advance, otherwise all hold.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      if (advance_s) begin
        stage_d[s] = lay_out_s[s];
        valid_d[s] = vin_s[s];
        desc_d[s]  = desc_in_s[s];
      end else begin
        stage_d[s] = stage_q[s];
        valid_d[s] = valid_q[s];
        desc_d[s]  = desc_q[s];
      end
    end
  end

  // Vectors in flight: +1 per input transfer, -1 per output transfer.
  always_comb begin
    case ({in_fire_s, out_fire_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Stage registers; reset discards everything in flight and clears data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= '0;
      end
      valid_q <= '0;
      desc_q  <= '0;
      occ_q   <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= stage_d[s];
      end
      valid_q <= valid_d;
      desc_q  <= desc_d;
      occ_q   <= occ_d;
    end
  end

  assign in_ready  = advance_s;
  assign out_valid = valid_q[STAGES-1];
  assign out_desc  = desc_q[STAGES-1];
  assign occupancy = occ_q;

  for (genvar i = 0; i < N; i++) begin : g_out
    assign out_data[i*DATA_W +: DATA_W] = stage_q[STAGES-1][i][EW-1 -: DATA_W];
`ifdef BITONIC_SORT_TAG_EN
    assign out_tag[i*LOG_N +: LOG_N] = stage_q[STAGES-1][i][TAG_W-1:0];
`endif
  end

endmodule

// File: doc/bitonic_sort_pipe.md
Name: bitonic_sort_pipe

Overview:
Parametrised, fully pipelined bitonic sorter for N = 2^LOG_N unsigned elements. It is the successor to the fixed 8-input combinational bitonic stages: it builds the complete sort network, registers every compare layer, and runs a valid/ready handshake with backpressure. Sort direction is selected per transaction. It sits between the data-capture front end and any downstream consumer of sorted vectors.

Parameters:
LOG_N, 3, log2 of element count; N = 2^LOG_N; legal range 1..5
DATA_W, 8, element width in bits (unsigned)
STAGES, LOG_N*(LOG_N+1)/2, derived localparam, not overridable; 6 when LOG_N=3

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  sorter accepts the input vector this cycle
in_desc  in  1  0 = ascending (element 0 smallest), 1 = descending
in_data  in  N*DATA_W  element i at bits [i*DATA_W +: DATA_W]
out_valid  out  1  sorted vector valid
out_ready  in  1  consumer accepts the output vector
out_desc  out  1  in_desc of the vector currently on the output
out_data  out  N*DATA_W  sorted vector, same packing as in_data
occupancy  out  $clog2(STAGES+1)  number of vectors in flight

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all stage valid bits clear, so out_valid=0 and occupancy=0
  - out_data=0, out_desc=0
  - data registers are also cleared
- Network:
  - standard bitonic merge network: STAGES compare layers, one register stage per layer
  - compare-and-swap on each pair (lo, hi): if a[lo] > a[hi] (unsigned) the pair is swapped for ascending order
  - the direction of each pair follows the standard bitonic index bit
  - the final merge direction is inverted when desc=1
  - equal keys are never swapped
- Transaction flags: each stage register holds data, valid and desc. desc travels with its vector.
- Advance rule: advance = !out_valid || out_ready. This is a global stall.
  - advance=1: every stage shifts one step
  - advance=0: every stage holds; bubbles are not compressed
- in_ready = advance. An input transfer happens when in_valid && in_ready.
- Output: the output transfer happens when out_valid && out_ready. Data and out_valid are stable while out_ready=0.
- Latency: a vector accepted in cycle t appears with out_valid=1 in cycle t+STAGES when there is no stall. Throughput is 1 vector/cycle.
- occupancy counter:
  - +1 on an input transfer, −1 on an output transfer
  - unchanged when both happen in the same cycle
  - never exceeds STAGES
- in_valid=0 while advancing inserts a bubble; the bubble is invisible at the output.
- Reset mid-operation: all in-flight vectors are discarded, with no partial output. The first vector after reset release sees full latency.
- Simultaneous in/out transfer when the pipeline is full is legal; it is the steady state.

Optional Feature:
BITONIC_SORT_TAG_EN
- Defined:
  - adds out_tag, output, N*LOG_N bits
  - out_tag element j = original input index of out_data element j (argsort)
  - tags travel through every compare-and-swap alongside their keys
  - ties compare on {key, tag}, so equal keys come out ordered by original index in the sort direction; the result is deterministic
- Undefined: no tag port and no tag registers; ties behave as above with no tag comparison.

Decomposition:
- Package bitonic_pkg:
  - function stage_count(log_n)
  - function pair_partner(layer, idx) and function pair_dir(layer, idx), both used at elaboration
  - localparam MAX_LOG_N=5
- Sub-module bitonic_cas:
  - combinational compare-and-swap for one pair
  - parameters DATA_W and TAG_W (0 = no tag)
  - inputs a, b, dir; outputs lo, hi
  - instantiated N/2 times per layer in generate loops

Test Plan:
- LOG_N=3, ascending, in_data elements 0..7 = {5,3,7,1,8,2,6,4}, out_ready=1 -> 6 cycles later out_data={1,2,3,4,5,6,7,8}, out_desc=0.
- Same vector with in_desc=1 -> out_data={8,7,6,5,4,3,2,1}, out_desc=1.
- Back-to-back: 20 random vectors on consecutive cycles with alternating desc -> 20 consecutive outputs, each sorted in its own direction, occupancy settles at 6.
- Backpressure: out_ready=0 for 4 cycles once out_valid=1 -> out_data stable, in_ready=0, no loss or duplication; release -> order preserved.
- Duplicates and extremes: {255,0,255,0,128,128,0,255} ascending -> {0,0,0,128,128,255,255,255}. With BITONIC_SORT_TAG_EN: out_tag={1,3,6,4,5,0,2,7}.
- Reset with 3 vectors in flight: rst_n pulsed low -> out_valid=0 and occupancy=0 immediately; no stale vector appears after release.
